// File: rtl/alu_pkg.sv
// Shared widths and opcode/shift encodings for the 32-bit ALU slice.
package alu_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned OPW   = 4;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOT  = 4'd5,
    OP_SLL  = 4'd6,
    OP_SRL  = 4'd7,
    OP_SRA  = 4'd8,
    OP_MUL  = 4'd9,
    OP_INC  = 4'd10,
    OP_DEC  = 4'd11,
    OP_SLT  = 4'd12,
    OP_SLTU = 4'd13,
    OP_NOR  = 4'd14,
    OP_PASS = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } shift_e;

endpackage

// File: rtl/alu_intf.sv
// Signal bundle carrying clock, reset and every alu_32bit port.
interface intf (
  input logic clk,
  input logic rst_n
);
  logic [alu_pkg::WIDTH-1:0] OperandA;
  logic [alu_pkg::WIDTH-1:0] OperandB;
  logic [alu_pkg::OPW-1:0]   op_code;
  logic [alu_pkg::WIDTH-1:0] data_out;
endinterface

// File: rtl/alu_shifter.sv
// Combinational log-stage barrel shifter for SLL/SRL/SRA.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = alu_pkg::WIDTH,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
  input  shift_e           mode,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] a_rev;
  logic [WIDTH-1:0] post;
  logic [WIDTH-1:0] post_rev;
  logic             fill;
  logic [WIDTH-1:0] stg [SHW+1];

  always_comb begin
    a_rev    = '0;
    post_rev = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      a_rev[i]    = a[SHW'(WIDTH - 1 - i)];
      post_rev[i] = post[SHW'(WIDTH - 1 - i)];
    end
  end

  // Left shifts reuse the right-shift stages on a bit-reversed operand.
  assign stg[0] = (mode == SH_SLL) ? a_rev : a;
  assign fill   = (mode == SH_SRA) & a[WIDTH-1];

  for (genvar g = 0; g < SHW; g++) begin : g_stage
    localparam int unsigned D = 1 << g;
    assign stg[g+1] = shamt[g] ? {{D{fill}}, stg[g][WIDTH-1:D]} : stg[g];
  end

  assign post = stg[SHW];
  assign y    = (mode == SH_SLL) ? post_rev : post;

endmodule

// File: rtl/alu_32bit.sv
// Registered 32-bit ALU: 16 operations, one-cycle latency, async active-high reset.
module alu_32bit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = alu_pkg::WIDTH,
  parameter int unsigned OPW   = alu_pkg::OPW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic [OPW-1:0]   op_code,
  output logic [WIDTH-1:0] data_out
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  alu_op_e          op;
  shift_e           shift_mode;
  logic [WIDTH-1:0] shift_y;
  logic [WIDTH-1:0] result;
  logic             lt_signed;
  logic             lt_unsigned;

  assign op          = alu_op_e'(op_code);
  assign lt_signed   = $signed(OperandA) < $signed(OperandB);
  assign lt_unsigned = OperandA < OperandB;

  always_comb begin
    shift_mode = SH_SLL;
    case (op)
      OP_SRL:  shift_mode = SH_SRL;
      OP_SRA:  shift_mode = SH_SRA;
      default: shift_mode = SH_SLL;
    endcase
  end

  alu_shifter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shifter (
    .a     (OperandA),
    .shamt (OperandB[SHW-1:0]),
    .mode  (shift_mode),
    .y     (shift_y)
  );

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = OperandA + OperandB;
      OP_SUB:  result = OperandA - OperandB;
      OP_AND:  result = OperandA & OperandB;
      OP_OR:   result = OperandA | OperandB;
      OP_XOR:  result = OperandA ^ OperandB;
      OP_NOT:  result = ~OperandA;
      OP_SLL:  result = shift_y;
      OP_SRL:  result = shift_y;
      OP_SRA:  result = shift_y;
      OP_MUL:  result = OperandA * OperandB;
      OP_INC:  result = OperandA + ONE;
      OP_DEC:  result = OperandA - ONE;
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, lt_signed};
      OP_SLTU: result = {{(WIDTH-1){1'b0}}, lt_unsigned};
      OP_NOR:  result = ~(OperandA | OperandB);
      OP_PASS: result = OperandA;
    endcase
  end

  // rst_n is active-high despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) data_out <= '0;
    else       data_out <= result;
  end

endmodule

// File: tb/tb_alu_32bit.sv
// Scoreboard bench for alu_32bit: driver queues expected results, monitor checks them.
module tb_alu_32bit;
  import alu_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  intf bus (.clk(clk), .rst_n(rst_n));

  alu_32bit #(
    .WIDTH (32),
    .OPW   (4)
  ) dut (
    .clk      (bus.clk),
    .rst_n    (bus.rst_n),
    .OperandA (bus.OperandA),
    .OperandB (bus.OperandB),
    .op_code  (bus.op_code),
    .data_out (bus.data_out)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] exp_q [$];
  string       name_q [$];

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } dir_t;

  localparam int NDIR = 20;
  dir_t dirs [NDIR] = '{
    '{4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000},
    '{4'd1,  32'h00000003, 32'h00000005, 32'hFFFFFFFE},
    '{4'd9,  32'h00010000, 32'h00010000, 32'h00000000},
    '{4'd9,  32'h00000003, 32'h00000005, 32'h0000000F},
    '{4'd10, 32'h7FFFFFFF, 32'h00000000, 32'h80000000},
    '{4'd11, 32'h00000000, 32'h00000000, 32'hFFFFFFFF},
    '{4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000},
    '{4'd3,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0},
    '{4'd4,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0},
    '{4'd14, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F},
    '{4'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0F0F0F0F},
    '{4'd6,  32'h80000001, 32'h00000004, 32'h00000010},
    '{4'd7,  32'h80000001, 32'h00000004, 32'h08000000},
    '{4'd8,  32'h80000001, 32'h00000004, 32'hF8000000},
    '{4'd6,  32'h80000001, 32'h00000020, 32'h80000001},
    '{4'd8,  32'h80000001, 32'h00000020, 32'h80000001},
    '{4'd12, 32'hFFFFFFFF, 32'h00000001, 32'h00000001},
    '{4'd13, 32'hFFFFFFFF, 32'h00000001, 32'h00000000},
    '{4'd15, 32'h12345678, 32'h9ABCDEF0, 32'h12345678},
    '{4'd8,  32'h40000000, 32'h0000001F, 32'h00000000}
  };

  function automatic logic [31:0] ref_model(input logic [3:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    int unsigned s;
    longint unsigned p;
    logic [31:0] ones;
    logic [31:0] r;
    s    = b % 32;
    ones = '1;
    r    = '0;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = ~a;
      4'd6:  r = a << s;
      4'd7:  r = a >> s;
      4'd8:  r = (a >> s) | (a[31] ? ~(ones >> s) : 32'h0);
      4'd9:  begin p = longint'(a) * longint'(b); r = p[31:0]; end
      4'd10: r = a + 32'd1;
      4'd11: r = a - 32'd1;
      4'd12: r = ((a ^ 32'h80000000) < (b ^ 32'h80000000)) ? 32'd1 : 32'd0;
      4'd13: r = (a < b) ? 32'd1 : 32'd0;
      4'd14: r = ~(a | b);
      default: r = a;
    endcase
    return r;
  endfunction

  function automatic void check(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
  endfunction

  task automatic issue(input logic r, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input string nm);
    @(negedge clk);
    rst_n        = r;
    bus.op_code  = op;
    bus.OperandA = a;
    bus.OperandB = b;
    exp_q.push_back(r ? 32'h0 : exp);
    name_q.push_back(nm);
  endtask

  task automatic issue_rand(input logic [3:0] op, input string nm);
    logic [31:0] a;
    logic [31:0] b;
    a = $urandom;
    b = $urandom;
    if ($urandom_range(0, 3) == 0) b = b & 32'h1F;
    issue(1'b0, op, a, b, ref_model(op, a, b), nm);
  endtask

  // Monitor: one registered result per rising edge.
  initial begin
    logic [31:0] e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check(nm, bus.data_out, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bus.op_code  = '0;
    bus.OperandA = '0;
    bus.OperandB = '0;

    repeat (3) issue(1'b1, 4'd0, 32'd5, 32'd3, 32'd0, "rst_hold");
    issue(1'b0, 4'd0, 32'd5, 32'd3, 32'd8, "rst_release");

    for (int i = 0; i < NDIR; i++)
      issue(1'b0, dirs[i].op, dirs[i].a, dirs[i].b, dirs[i].exp, $sformatf("dir%0d", i));

    for (int i = 0; i < 16; i++) issue_rand(4'(i), $sformatf("sweep_op%0d", i));

    issue(1'b0, 4'd0, 32'h11111111, 32'h22222222, 32'h33333333, "pre_async");
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    check("async_rst", bus.data_out, 32'h0);
    issue(1'b1, 4'd15, 32'hDEADBEEF, 32'h0, 32'h0, "in_reset");
    issue(1'b0, 4'd15, 32'hCAFEF00D, 32'h0, 32'hCAFEF00D, "after_async");

    for (int i = 0; i < 200; i++) issue_rand(4'($urandom_range(0, 15)), "rand");

    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
